rom_read_arbiter: RTL and testbench

//  Shares one single-port ROM (registered output, 1-cycle read) among NUM_REQ

---
 rtl/rom_read_arbiter_pkg.sv | 43 ++++
 rtl/rom_read_arbiter_if.sv | 29 ++
 rtl/rom_read_arbiter_rr_arbiter.sv | 22 ++
 rtl/rom_read_arbiter.sv | 76 +++++++
 tb/tb_rom_read_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and helpers for the ROM read arbiter: response tag layout,
// round-robin pick and one-hot to index conversion.
package rom_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int ID_BITS = 4;

    typedef struct packed {
        logic               vld;
        logic [ID_BITS-1:0] id;
        logic               err;
    } rsp_tag_t;

    // Scan from ptr upward with wrap-around over n requesters; first set bit wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [ID_BITS-1:0] ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx -= n;
            if (k < n && !found && idx < MAX_REQ && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic logic [ID_BITS-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [ID_BITS-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) idx |= ID_BITS'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester and ROM side bus of the ROM read arbiter; slave = arbiter view,
// master = requesters plus ROM view.
interface rom_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic [NUM_REQ-1:0]           REQ_VALID;
    logic [NUM_REQ*ADDR_BITS-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]           REQ_READY;
    logic [NUM_REQ-1:0]           RSP_VALID;
    logic [WIDTH-1:0]             RSP_DATA;
    logic                         RSP_ERR;
    logic [ADDR_BITS-1:0]         ROM_ADDRESS;
    logic [WIDTH-1:0]             ROM_DATAOUT;

    modport slave (
        input  REQ_VALID, REQ_ADDR, ROM_DATAOUT,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ROM_ADDRESS
    );

    modport master (
        output REQ_VALID, REQ_ADDR, ROM_DATAOUT,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ROM_ADDRESS
    );

endinterface

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: one-hot grant plus its index.
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);

    logic [MAX_REQ-1:0] pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), ID_BITS'(ptr), NUM_REQ);
        grant = pick[NUM_REQ-1:0];
        idx   = IDW'(onehot2idx(pick));
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output single-port ROM among NUM_REQ requesters with
// round-robin grants and a fixed 2-cycle, in-order, tagged response pipeline.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8
) (
    input logic                 CLK,
    input logic                 RSTn,
    rom_read_arbiter_if.slave   bus
);

    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int IDW       = $clog2(NUM_REQ);
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       gidx;
    logic [NUM_REQ-1:0]   grant;
    logic                 hs;
    logic [ADDR_BITS-1:0] win_addr;
    logic [ADDR_BITS-1:0] held_addr;
    logic                 win_err;
    rsp_tag_t             s1;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .valid (bus.REQ_VALID),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
    always_comb begin
        bus.REQ_READY   = RSTn ? grant : '0;
        hs              = |(bus.REQ_READY & bus.REQ_VALID);
        win_addr        = bus.REQ_ADDR[gidx*ADDR_BITS +: ADDR_BITS];
        win_err         = {1'b0, win_addr} >= DEPTH_W;
        // Idle cycles replay the last granted address so the ROM input stays quiet.
        bus.ROM_ADDRESS = hs ? win_addr : held_addr;
    end

    // NOTE: registers use <= so each one samples pre-edge values of the others.
    // NOTE: response data/tag registers are reset because RSP_DATA must read 0 after reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr           <= '0;
            held_addr     <= '0;
            s1            <= '0;
            bus.RSP_VALID <= '0;
            bus.RSP_DATA  <= '0;
            bus.RSP_ERR   <= 1'b0;
        end else begin
            if (hs) begin
                ptr       <= (gidx == IDW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                held_addr <= win_addr;
            end
            s1            <= '{vld: hs, id: ID_BITS'(gidx), err: win_err};
            bus.RSP_VALID <= s1.vld ? (NUM_REQ'(1) << s1.id) : '0;
            if (s1.vld) begin
                bus.RSP_DATA <= s1.err ? '0 : bus.ROM_DATAOUT;
                bus.RSP_ERR  <= s1.err;
            end
        end
    end

    // A pending request must keep VALID and ADDR stable until it is accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
        a_hold : assert property (@(posedge CLK) disable iff (!RSTn)
            (bus.REQ_VALID[i] && !bus.REQ_READY[i]) |=>
            (bus.REQ_VALID[i] && $stable(bus.REQ_ADDR[i*ADDR_BITS +: ADDR_BITS])));
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench: a DEPTH=8 and a DEPTH=6 arbiter, each with its own ROM model,
// reference round-robin model, expected-response queue and response monitor.
module tb_rom_read_arbiter;

    localparam int NR = 4;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0] v_drv [2];
    logic [2:0]    a_drv [2][NR];

    rom_read_arbiter_if #(.NUM_REQ(NR), .WIDTH(8), .DEPTH(8)) bus_a ();
    rom_read_arbiter_if #(.NUM_REQ(NR), .WIDTH(8), .DEPTH(6)) bus_b ();

    assign bus_a.REQ_VALID = v_drv[0];
    assign bus_a.REQ_ADDR  = {a_drv[0][3], a_drv[0][2], a_drv[0][1], a_drv[0][0]};
    assign bus_b.REQ_VALID = v_drv[1];
    assign bus_b.REQ_ADDR  = {a_drv[1][3], a_drv[1][2], a_drv[1][1], a_drv[1][0]};

    // ROM models: rom[k] = 8'h10 + k; the 6-word ROM returns junk beyond its end.
    always @(posedge clk) bus_a.ROM_DATAOUT <= 8'h10 + 8'(bus_a.ROM_ADDRESS);
    always @(posedge clk)
        bus_b.ROM_DATAOUT <= (bus_b.ROM_ADDRESS < 3'd6) ? 8'h10 + 8'(bus_b.ROM_ADDRESS) : 8'hEE;

    rom_read_arbiter #(.NUM_REQ(NR), .WIDTH(8), .DEPTH(8)) dut_a (
        .CLK (clk), .RSTn (rst_n), .bus (bus_a.slave));
    rom_read_arbiter #(.NUM_REQ(NR), .WIDTH(8), .DEPTH(6)) dut_b (
        .CLK (clk), .RSTn (rst_n), .bus (bus_b.slave));

    logic [NR-1:0] rdy_s [2];
    logic [NR-1:0] rv_s  [2];
    logic [7:0]    rd_s  [2];
    logic          re_s  [2];

    assign rdy_s[0] = bus_a.REQ_READY;
    assign rdy_s[1] = bus_b.REQ_READY;
    assign rv_s[0]  = bus_a.RSP_VALID;
    assign rv_s[1]  = bus_b.RSP_VALID;
    assign rd_s[0]  = bus_a.RSP_DATA;
    assign rd_s[1]  = bus_b.RSP_DATA;
    assign re_s[0]  = bus_a.RSP_ERR;
    assign re_s[1]  = bus_b.RSP_ERR;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_chk
        localparam int DEP = (k == 0) ? 8 : 6;

        exp_t       sb[$];
        int         ptr_m   = 0;
        int         last_hs = -1;
        logic [7:0] last_d  = 8'h00;
        logic       last_e  = 1'b0;

        // Round robin from the rules: first VALID at or after ptr, wrapping.
        function automatic int pick(input logic [NR-1:0] v, input int p);
            for (int j = 0; j < NR; j++)
                if (v[(p + j) % NR]) return (p + j) % NR;
            return -1;
        endfunction

        // Grant checker and scoreboard producer.
        always @(negedge clk) begin
            int   g;
            exp_t e;
            if (!rst_n) begin
                sb.delete();
                ptr_m   = 0;
                last_hs = -1;
                check($sformatf("ready_in_reset%0d", k), 32'(rdy_s[k]), 32'd0);
            end else begin
                g = pick(v_drv[k], ptr_m);
                check($sformatf("grant%0d", k), 32'(rdy_s[k]), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    e.id   = g;
                    e.err  = (int'(a_drv[k][g]) >= DEP);
                    e.data = e.err ? 8'h00 : 8'h10 + 8'(a_drv[k][g]);
                    e.due  = cyc + 2;
                    sb.push_back(e);
                    ptr_m = (g + 1) % NR;
                end
                last_hs = g;
            end
        end

        // Response monitor and scoreboard consumer.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                check($sformatf("rsp_valid_reset%0d", k), 32'(rv_s[k]), 32'd0);
                check($sformatf("rsp_data_reset%0d", k), 32'(rd_s[k]), 32'd0);
                check($sformatf("rsp_err_reset%0d", k), 32'(re_s[k]), 32'd0);
                last_d = 8'h00;
                last_e = 1'b0;
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check($sformatf("rsp_valid%0d", k), 32'(rv_s[k]), 32'd1 << e.id);
                check($sformatf("rsp_data%0d", k), 32'(rd_s[k]), 32'(e.data));
                check($sformatf("rsp_err%0d", k), 32'(re_s[k]), 32'(e.err));
                last_d = e.data;
                last_e = e.err;
            end else begin
                check($sformatf("rsp_idle%0d", k), 32'(rv_s[k]), 32'd0);
                check($sformatf("rsp_data_hold%0d", k), 32'(rd_s[k]), 32'(last_d));
                check($sformatf("rsp_err_hold%0d", k), 32'(re_s[k]), 32'(last_e));
            end
        end
    end

    function automatic int get_hs(input int k);
        return (k == 0) ? g_chk[0].last_hs : g_chk[1].last_hs;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic renew(input int k);
        int h;
        h = get_hs(k);
        if (h >= 0) a_drv[k][h] = 3'($urandom_range(0, 7));
    endtask

    task automatic drop(input int k);
        int h;
        h = get_hs(k);
        if (h >= 0) v_drv[k][h] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((v_drv[0] != '0 || v_drv[1] != '0) && n < 40) begin
            tick();
            drop(0);
            drop(1);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        v_drv[0] = '0;
        v_drv[1] = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) a_drv[k][i] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All requesters held: grants 0,1,2,3,0 from a fresh pointer.
        v_drv[0] = 4'b1111;
        repeat (5) begin
            tick();
            renew(0);
        end
        drain();

        // Wrap and skip: grant 2, then only 0 and 1 requesting.
        v_drv[0] = 4'b0100;
        tick();
        v_drv[0] = 4'b0011;
        tick();
        drop(0);
        tick();
        drop(0);

        // Single read: requester 1, address 3.
        v_drv[0]    = 4'b0010;
        a_drv[0][1] = 3'd3;
        tick();
        v_drv[0] = '0;

        // Streaming from requester 3 over every address.
        v_drv[0]    = 4'b1000;
        a_drv[0][3] = 3'd0;
        for (int j = 1; j < 8; j++) begin
            tick();
            a_drv[0][3] = 3'(j);
        end
        tick();
        v_drv[0] = '0;

        // Out of range on the 6-word build, then legal, then out of range again.
        v_drv[1]    = 4'b0100;
        a_drv[1][2] = 3'd7;
        tick();
        a_drv[1][2] = 3'd5;
        tick();
        a_drv[1][2] = 3'd6;
        tick();
        v_drv[1] = '0;
        repeat (3) tick();

        // Reset while reads are in flight, with requests pending across release.
        v_drv[0] = 4'b1111;
        tick();
        renew(0);
        tick();
        rst_n    = 1'b0;
        v_drv[0] = 4'b0110;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        drop(0);
        drain();

        // Randomized traffic on both builds, obeying the hold rule.
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NR; i++) begin
                    if (!v_drv[k][i] || get_hs(k) == i) begin
                        v_drv[k][i] = 1'($urandom_range(0, 1));
                        a_drv[k][i] = 3'($urandom_range(0, 7));
                    end
                end
            end
            tick();
        end
        drain();
        repeat (4) tick();

        check("sb_left0", 32'(g_chk[0].sb.size()), 32'd0);
        check("sb_left1", 32'(g_chk[1].sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
